// File: rtl/mul_defs.sv
// Shared definitions for the HI/LO multiply controller and its multiplier.
package mul_defs;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned MUL_LAT_DEFAULT = 1;

    // EXE-stage operation codes
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_MTHI  = 2'b10,
        OP_MTLO  = 2'b11
    } op_e;

    // Controller state
    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

    // Full 64-bit product split into the architectural halves
    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } prod_t;

endpackage

// File: rtl/mul.sv
// Pipelined 32x32 multiplier; signed or unsigned per mul_signed, result LATENCY edges after operands.
module mul
    import mul_defs::*;
#(
    parameter int unsigned LATENCY = MUL_LAT_DEFAULT
) (
    input  logic                mul_clk,
    input  logic                resetn,
    input  logic [XLEN-1:0]     x,
    input  logic [XLEN-1:0]     y,
    input  logic                mul_signed,
    output logic [2*XLEN-1:0]   result
);

    logic [2*XLEN-1:0] w_xe;
    logic [2*XLEN-1:0] w_ye;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] r_pipe [LATENCY];

    // Extend to 64 bits so a modulo-2^64 product is exact for both signednesses
    assign w_xe   = {{XLEN{mul_signed & x[XLEN-1]}}, x};
    assign w_ye   = {{XLEN{mul_signed & y[XLEN-1]}}, y};
    assign w_prod = w_xe * w_ye;

    // Product pipeline
    always_ff @(posedge mul_clk) begin
        if (!resetn) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_prod;
            for (int i = 1; i < int'(LATENCY); i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign result = r_pipe[LATENCY-1];

endmodule

// File: rtl/hilo_mul_ctrl.sv
// HI/LO controller: accepts MULT/MULTU/MTHI/MTLO from EXE, sequences the multiplier, owns HI/LO.
module hilo_mul_ctrl
    import mul_defs::*;
#(
    parameter int unsigned MUL_LATENCY = MUL_LAT_DEFAULT
) (
    input  logic              mul_clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [XLEN-1:0]   req_a,
    input  logic [XLEN-1:0]   req_b,
    input  logic              cancel,
    output logic [XLEN-1:0]   hi,
    output logic [XLEN-1:0]   lo,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = (MUL_LATENCY > 0) ? $clog2(MUL_LATENCY + 1) : 1;

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [XLEN-1:0]    r_a;
    logic [XLEN-1:0]    r_b;
    logic               r_signed;
    logic [XLEN-1:0]    r_hi;
    logic [XLEN-1:0]    r_lo;
    logic               r_done;

    op_e                w_op;
    logic               w_accept;
    prod_t              w_result;

    assign w_op      = op_e'(req_op);
    assign req_ready = resetn & (r_state == IDLE) & ~cancel;
    assign w_accept  = req_valid & req_ready;

    // Multiplier sees only latched operands so they stay stable for the whole MUL window
    mul #(
        .LATENCY    (MUL_LATENCY)
    ) u_mul (
        .mul_clk    (mul_clk),
        .resetn     (resetn),
        .x          (r_a),
        .y          (r_b),
        .mul_signed (r_signed),
        .result     (w_result)
    );

    // Control FSM with HI/LO, operand and done registers
    always_ff @(posedge mul_clk) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        case (w_op)
                            OP_MULT, OP_MULTU: begin
                                r_a      <= req_a;
                                r_b      <= req_b;
                                r_signed <= (w_op == OP_MULT);
                                r_cnt    <= CNT_W'(MUL_LATENCY);
                                r_state  <= MUL;
                            end
                            OP_MTHI: r_hi <= req_a;
                            OP_MTLO: r_lo <= req_a;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    // A flush always beats the pending write-back
                    if (cancel) begin
                        r_state <= IDLE;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_hi    <= w_result.hi;
                        r_lo    <= w_result.lo;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = (r_state == MUL);
    assign done = r_done;

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// Scoreboard bench for hilo_mul_ctrl with the real multiplier.
module tb_hilo_mul_ctrl;
    import mul_defs::*;

    logic        mul_clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        cancel;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q [$];

    always #5 mul_clk = ~mul_clk;

    hilo_mul_ctrl #(
        .MUL_LATENCY (1)
    ) dut (
        .mul_clk   (mul_clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .cancel    (cancel),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Present a request at a negedge and hold it until accepted; returns at the next negedge
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [63:0] exp,
                         output int waited, output logic done_at_accept);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        waited    = 0;
        #1;
        while (req_ready !== 1'b1 && waited < 20) begin
            @(negedge mul_clk);
            #1;
            waited++;
        end
        done_at_accept = done;
        chk("accept", 64'(req_ready), 64'd1);
        if (push) exp_q.push_back(exp);
        @(negedge mul_clk);
        req_valid = 1'b0;
    endtask

    // Monitor: every done pulse must match the oldest outstanding product
    always @(negedge mul_clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done hi=%h lo=%h", hi, lo);
            end else begin
                chk("mon_product", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int   w;
        logic d;

        // 1. Reset held with a pending request
        resetn    = 1'b0;
        req_valid = 1'b1;
        req_op    = OP_MULT;
        req_a     = 32'd3;
        req_b     = 32'd3;
        cancel    = 1'b0;
        repeat (3) begin
            @(negedge mul_clk);
            chk("rst_hi", 64'(hi), 64'd0);
            chk("rst_lo", 64'(lo), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_done", 64'(done), 64'd0);
            chk("rst_ready", 64'(req_ready), 64'd0);
        end
        resetn    = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("post_rst_ready", 64'(req_ready), 64'd1);
        @(negedge mul_clk);
        chk("post_rst_ready2", 64'(req_ready), 64'd1);

        // 2. Signed MULT -2 * 3
        issue(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, w, d);
        chk("t2_busy_c1", 64'(busy), 64'd1);
        chk("t2_done_c1", 64'(done), 64'd0);
        @(negedge mul_clk);
        chk("t2_busy_c2", 64'(busy), 64'd1);
        @(negedge mul_clk);
        chk("t2_busy_c3", 64'(busy), 64'd0);
        chk("t2_done_c3", 64'(done), 64'd1);
        chk("t2_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("t2_lo", 64'(lo), 64'hFFFF_FFFA);
        @(negedge mul_clk);
        chk("t2_done_c4", 64'(done), 64'd0);

        // 3. MULTU and MULT of all-ones
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001, w, d);
        repeat (2) @(negedge mul_clk);
        chk("t3u_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("t3u_lo", 64'(lo), 64'h0000_0001);
        issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, w, d);
        repeat (2) @(negedge mul_clk);
        chk("t3s_hi", 64'(hi), 64'h0);
        chk("t3s_lo", 64'(lo), 64'h1);
        @(negedge mul_clk);

        // 4. MTHI then MTLO on consecutive cycles
        issue(OP_MTHI, 32'h1234_5678, 32'h0, 1'b0, 64'h0, w, d);
        chk("t4_mthi_wait", 64'(w), 64'd0);
        chk("t4_hi", 64'(hi), 64'h1234_5678);
        chk("t4_busy1", 64'(busy), 64'd0);
        issue(OP_MTLO, 32'h9ABC_DEF0, 32'h0, 1'b0, 64'h0, w, d);
        chk("t4_mtlo_wait", 64'(w), 64'd0);
        chk("t4_lo", 64'(lo), 64'h9ABC_DEF0);
        chk("t4_hi_kept", 64'(hi), 64'h1234_5678);
        chk("t4_busy2", 64'(busy), 64'd0);
        chk("t4_done", 64'(done), 64'd0);

        // 5. MULT 7*6 cancelled in its final MUL cycle
        issue(OP_MULT, 32'd7, 32'd6, 1'b0, 64'h0, w, d);
        chk("t5_busy_c1", 64'(busy), 64'd1);
        @(negedge mul_clk);
        cancel = 1'b1;
        #1;
        chk("t5_ready_cancel", 64'(req_ready), 64'd0);
        @(negedge mul_clk);
        cancel = 1'b0;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_done", 64'(done), 64'd0);
        chk("t5_hi", 64'(hi), 64'h1234_5678);
        chk("t5_lo", 64'(lo), 64'h9ABC_DEF0);
        #1;
        chk("t5_ready_after", 64'(req_ready), 64'd1);

        // 5b. cancel with a request in IDLE accepts nothing
        @(negedge mul_clk);
        cancel    = 1'b1;
        req_valid = 1'b1;
        req_op    = OP_MTHI;
        req_a     = 32'hDEAD_BEEF;
        @(negedge mul_clk);
        cancel    = 1'b0;
        req_valid = 1'b0;
        chk("t5b_hi", 64'(hi), 64'h1234_5678);
        chk("t5b_busy", 64'(busy), 64'd0);

        // 6. Second op held during busy, accepted in the done cycle
        issue(OP_MULT, 32'h0001_0000, 32'h0001_0000, 1'b1, 64'h0000_0001_0000_0000, w, d);
        issue(OP_MULTU, 32'h8000_0000, 32'h0000_0004, 1'b1, 64'h0000_0002_0000_0000, w, d);
        chk("t6_wait", 64'(w), 64'd2);
        chk("t6_done_at_accept", 64'(d), 64'd1);
        chk("t6_hi_first", 64'(hi), 64'h1);
        chk("t6_busy", 64'(busy), 64'd1);
        @(negedge mul_clk);
        @(negedge mul_clk);
        chk("t6_done2", 64'(done), 64'd1);
        chk("t6_hi", 64'(hi), 64'h2);
        chk("t6_lo", 64'(lo), 64'h0);

        // 7. Reset mid-MUL drops the pending result
        @(negedge mul_clk);
        issue(OP_MULT, 32'd5, 32'd5, 1'b0, 64'h0, w, d);
        resetn = 1'b0;
        @(negedge mul_clk);
        resetn = 1'b1;
        chk("t7_hi", 64'(hi), 64'h0);
        chk("t7_lo", 64'(lo), 64'h0);
        chk("t7_busy", 64'(busy), 64'd0);
        repeat (4) @(negedge mul_clk);
        chk("t7_hi_late", 64'(hi), 64'h0);
        chk("t7_done", 64'(done), 64'd0);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
